// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the register bank write port.
interface regfile_wb_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                       a_valid;
    logic                       a_ready;
    logic [ADDR_WIDTH-1:0]      a_rd;
    logic [DATA_WIDTH-1:0]      a_data;
    logic                       b_valid;
    logic                       b_ready;
    logic [ADDR_WIDTH-1:0]      b_rd;
    logic [DATA_WIDTH-1:0]      b_data;
    logic [ADDR_WIDTH-1:0]      rf_rd;
    logic [DATA_WIDTH-1:0]      rf_writeData;
    logic                       rf_regWrite;
    logic [2**ADDR_WIDTH-1:0]   pending_mask;

    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        input  a_ready, b_ready, rf_rd, rf_writeData, rf_regWrite, pending_mask
    );

    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        output a_ready, b_ready, rf_rd, rf_writeData, rf_regWrite, pending_mask
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter for the register bank write port: one-entry buffers,
// oldest-first grant with round-robin tie-break, registered active-low strobe, pending mask.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    regfile_wb_arbiter_if.slave   bus
);
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    buf_state_e             r_a_state, r_b_state, w_a_state_nxt, w_b_state_nxt;
    logic [ADDR_WIDTH-1:0]  r_a_rd, r_b_rd;
    logic [DATA_WIDTH-1:0]  r_a_data, r_b_data;
    logic                   r_rr_b;
    logic                   r_age_vld, r_age_b;
    logic                   w_age_vld_nxt, w_age_b_nxt;
    logic [ADDR_WIDTH-1:0]  r_rf_rd;
    logic [DATA_WIDTH-1:0]  r_rf_data;
    logic                   r_rf_we_n;

    logic                   w_a_full, w_b_full;
    logic                   w_grant_a, w_grant_b, w_tie;
    logic                   w_a_ready, w_b_ready;
    logic                   w_load_a, w_load_b;
    logic [2**ADDR_WIDTH-1:0] w_mask;

    // Grant selection over full buffers: age flag first, round-robin only on a same-cycle tie.
    always_comb begin
        w_a_full  = (r_a_state == BUF_FULL);
        w_b_full  = (r_b_state == BUF_FULL);
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        w_tie     = 1'b0;
        if (w_a_full && w_b_full) begin
            if (r_age_vld) begin
                w_grant_a = ~r_age_b;
                w_grant_b = r_age_b;
            end else begin
                w_tie     = 1'b1;
                w_grant_a = ~r_rr_b;
                w_grant_b = r_rr_b;
            end
        end else begin
            w_grant_a = w_a_full;
            w_grant_b = w_b_full;
        end
        w_a_ready = ~w_a_full | w_grant_a;
        w_b_ready = ~w_b_full | w_grant_b;
        w_load_a  = bus.a_valid & w_a_ready & (bus.a_rd != {ADDR_WIDTH{1'b0}});
        w_load_b  = bus.b_valid & w_b_ready & (bus.b_rd != {ADDR_WIDTH{1'b0}});
    end

    // Buffer next-state and age tracking; a buffer left waiting while the other refills is older.
    always_comb begin
        w_a_state_nxt = r_a_state;
        w_b_state_nxt = r_b_state;
        case (r_a_state)
            BUF_EMPTY: w_a_state_nxt = w_load_a ? BUF_FULL : BUF_EMPTY;
            BUF_FULL:  w_a_state_nxt = (w_grant_a && !w_load_a) ? BUF_EMPTY : BUF_FULL;
            default:   w_a_state_nxt = BUF_EMPTY;
        endcase
        case (r_b_state)
            BUF_EMPTY: w_b_state_nxt = w_load_b ? BUF_FULL : BUF_EMPTY;
            BUF_FULL:  w_b_state_nxt = (w_grant_b && !w_load_b) ? BUF_EMPTY : BUF_FULL;
            default:   w_b_state_nxt = BUF_EMPTY;
        endcase
        if (w_a_full && !w_grant_a && w_load_b) begin
            w_age_vld_nxt = 1'b1;
            w_age_b_nxt   = 1'b0;
        end else if (w_b_full && !w_grant_b && w_load_a) begin
            w_age_vld_nxt = 1'b1;
            w_age_b_nxt   = 1'b1;
        end else begin
            w_age_vld_nxt = 1'b0;
            w_age_b_nxt   = 1'b0;
        end
    end

    // Buffer contents, arbitration state and the registered write-port stage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a_state <= BUF_EMPTY;
            r_b_state <= BUF_EMPTY;
            r_a_rd    <= {ADDR_WIDTH{1'b0}};
            r_b_rd    <= {ADDR_WIDTH{1'b0}};
            r_a_data  <= {DATA_WIDTH{1'b0}};
            r_b_data  <= {DATA_WIDTH{1'b0}};
            r_rr_b    <= 1'b0;
            r_age_vld <= 1'b0;
            r_age_b   <= 1'b0;
            r_rf_rd   <= {ADDR_WIDTH{1'b0}};
            r_rf_data <= {DATA_WIDTH{1'b0}};
            r_rf_we_n <= 1'b1;
        end else begin
            r_a_state <= w_a_state_nxt;
            r_b_state <= w_b_state_nxt;
            r_age_vld <= w_age_vld_nxt;
            r_age_b   <= w_age_b_nxt;
            if (w_tie) begin
                r_rr_b <= ~r_rr_b;
            end
            if (w_load_a) begin
                r_a_rd   <= bus.a_rd;
                r_a_data <= bus.a_data;
            end
            if (w_load_b) begin
                r_b_rd   <= bus.b_rd;
                r_b_data <= bus.b_data;
            end
            if (w_grant_a) begin
                r_rf_rd   <= r_a_rd;
                r_rf_data <= r_a_data;
                r_rf_we_n <= 1'b0;
            end else if (w_grant_b) begin
                r_rf_rd   <= r_b_rd;
                r_rf_data <= r_b_data;
                r_rf_we_n <= 1'b0;
            end else begin
                r_rf_we_n <= 1'b1;
            end
        end
    end

    // Pending-write mask from registered state only.
    always_comb begin
        w_mask = {(2**ADDR_WIDTH){1'b0}};
        if (w_a_full) begin
            w_mask[r_a_rd] = 1'b1;
        end
        if (w_b_full) begin
            w_mask[r_b_rd] = 1'b1;
        end
        if (!r_rf_we_n) begin
            w_mask[r_rf_rd] = 1'b1;
        end
    end

    assign bus.a_ready      = w_a_ready;
    assign bus.b_ready      = w_b_ready;
    assign bus.rf_rd        = r_rf_rd;
    assign bus.rf_writeData = r_rf_data;
    assign bus.rf_regWrite  = r_rf_we_n;
    assign bus.pending_mask = w_mask;
endmodule
